sram_burst_reader: RTL and testbench

Burst read sequencer sitting directly upstream of the 32×32 `sram` block. It drives the SRAM address port and accounts for the SRAM's one-cycle registered read latency. Returned words are presented on a valid/ready output stream with backpressure. It replaces hand-stepped address generation with a start/base/length command interface, so downstream logic can consume SRAM contents as a stream.

---
 rtl/sram_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/sram_burst_reader.sv | 177 +++++++++++++++++
 tb/tb_sram_burst_reader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
//   Shared constants and types for the 32x32 SRAM and its burst reader.
//   ADDR_W / DATA_W  : geometry of the sram block (32 words of 32 bits)
//   rd_state_t       : burst reader FSM encoding (IDLE, ISSUE, DRAIN)
//   sram_word_t      : one SRAM data word
// -----------------------------------------------------------------------------
package sram_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  typedef logic [DATA_W-1:0] sram_word_t;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with occupancy count. The head word is presented
//   combinationally on pop_data (first-word fall-through) and reads as zero
//   while the FIFO is empty.
//
//   Ports:
//     clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//     push       : write push_data this cycle (ignored when full and not popping)
//     push_data  : word to write
//     pop        : consume the head word this cycle (ignored when empty)
//     pop_data   : current head word, zero when empty
//     empty      : no words held
//     count      : number of words held, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is still safe when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_burst_reader.sv
// -----------------------------------------------------------------------------
// sram_burst_reader
//   Turns a start/base/len command into a sequence of SRAM addresses and
//   delivers the returned words as a valid/ready stream. The SRAM has a
//   one-cycle registered read and no enable, so a two-stage tag pipeline
//   marks which returning words belong to the burst.
//
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     start      : command strobe, honoured only in IDLE
//     base       : first word address of the burst
//     len        : burst length in words, 0..2**ADDR_W
//     busy       : burst in progress (ISSUE or DRAIN)
//     done       : one-cycle pulse when a burst (including len=0) completes
//     sram_adr   : registered address to the SRAM
//     sram_data  : SRAM read data, one cycle after sram_adr is sampled
//     out_data   : stream data (zero while out_valid is low)
//     out_valid  : stream valid
//     out_ready  : stream ready from the consumer
//     dbg_state  : current FSM state
//
//   Stream handshake: a word moves when out_valid && out_ready on a rising
//   edge. Once out_valid is raised, it and out_data stay unchanged until that
//   transfer happens.
//
//   Pipeline for an address placed on sram_adr at edge e:
//     e   : sram_adr loaded,          tag_adr  <= 1
//     e+1 : SRAM samples sram_adr,    tag_data <= 1
//     e+2 : sram_data pushed into the FIFO, out_valid rises
//   FIFO_DEPTH must be at least 4 to sustain one word per cycle.
// -----------------------------------------------------------------------------
module sram_burst_reader
  import sram_pkg::*;
#(
  parameter int ADDR_W     = sram_pkg::ADDR_W,
  parameter int DATA_W     = sram_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_adr,
  input  logic [DATA_W-1:0] sram_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output rd_state_t         dbg_state
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  rd_state_t         state;
  rd_state_t         state_nxt;
  logic [ADDR_W-1:0] adr_nxt;
  logic [ADDR_W:0]   rem;          // addresses still to issue
  logic [ADDR_W:0]   rem_nxt;
  logic              issue;        // a burst address goes onto sram_adr this edge
  logic              done_nxt;

  logic              tag_adr;      // sram_adr holds a burst address
  logic              tag_data;     // sram_data holds a burst word
  logic [1:0]        inflight;
  logic [CNT_W:0]    occupancy;
  logic              credit_ok;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              pop;

  // ---------------------------------------------------------------------------
  // Credit accounting: every word already in the FIFO or still in the SRAM
  // pipeline owns a FIFO slot, so a new address is issued only if a slot is
  // left for it even when the consumer stalls indefinitely.
  // ---------------------------------------------------------------------------
  assign inflight  = {1'b0, tag_adr} + {1'b0, tag_data};
  assign occupancy = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(inflight);
  assign credit_ok = occupancy < (CNT_W + 1)'(FIFO_DEPTH);

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // FSM next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    adr_nxt   = sram_adr;
    rem_nxt   = rem;
    issue     = 1'b0;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            // Empty burst: acknowledge without touching the SRAM.
            done_nxt = 1'b1;
          end else begin
            // The FIFO is empty in IDLE, so the first address always has credit.
            adr_nxt   = base;
            rem_nxt   = len - 1'b1;
            issue     = 1'b1;
            state_nxt = (len == (ADDR_W + 1)'(1)) ? DRAIN : ISSUE;
          end
        end
      end

      ISSUE: begin
        if (credit_ok) begin
          // Natural ADDR_W-bit overflow gives the modulo-2**ADDR_W wrap.
          adr_nxt = sram_adr + 1'b1;
          rem_nxt = rem - 1'b1;
          issue   = 1'b1;
          if (rem == (ADDR_W + 1)'(1)) state_nxt = DRAIN;
        end
      end

      DRAIN: begin
        // Finish on the edge where the last word leaves the stream, so done
        // appears in the cycle right after the final transfer.
        if (inflight == 2'd0 &&
            (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop))) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, address, length counter and tag pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sram_adr <= '0;
      rem      <= '0;
      tag_adr  <= 1'b0;
      tag_data <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sram_adr <= adr_nxt;
      rem      <= rem_nxt;
      tag_adr  <= issue;
      tag_data <= tag_adr;
      done     <= done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Output buffer
  // ---------------------------------------------------------------------------
  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_data),
    .push_data (sram_data),
    .pop       (pop),
    .pop_data  (out_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_sram_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_sram_burst_reader
//   Directed bench for sram_burst_reader with a behavioural 32x32 SRAM
//   (registered read, no enable) holding word i = 0xA500_0000 + i.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge;
//   "k" inside a test counts edges since the start was accepted (k=0 is the
//   accepting edge).
// -----------------------------------------------------------------------------
module tb_sram_burst_reader;
  import sram_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  base;
  logic [5:0]  len;
  logic        busy;
  logic        done;
  logic [4:0]  sram_adr;
  logic [31:0] sram_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  rd_state_t   dbg_state;

  sram_word_t  mem [32];
  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_errors;

  always #5 clk = ~clk;

  // Behavioural SRAM: reads every cycle, data one clock after the address.
  always @(posedge clk) sram_data <= mem[sram_adr];

  sram_burst_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .sram_adr  (sram_adr),
    .sram_data (sram_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [4:0] b, input logic [5:0] l);
    start = 1'b1;
    base  = b;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic expect_words(input logic [4:0] b, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(32'hA500_0000 + 32'(5'(b + 5'(i))));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (sram_adr !== 5'd0) begin n_errors++; $display("FAIL reset_adr: got %0d expected 0", sram_adr); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
    n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL reset_state: got %0d expected IDLE", dbg_state); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_burst();
    int first_k = -1;
    int done_k  = -1;
    int got     = 0;
    logic [31:0] exp_w;
    out_ready = 1'b1;
    expect_words(5'd0, 32);
    issue_cmd(5'd0, 6'd32);
    n_checks++; if (busy !== 1'b1 || sram_adr !== 5'd0) begin n_errors++; $display("FAIL full_accept: busy=%b adr=%0d expected busy=1 adr=0", busy, sram_adr); end
    for (int k = 1; k <= 45 && done_k < 0; k++) begin
      step();
      if (out_valid === 1'b1 && first_k < 0) first_k = k;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_errors++; $display("FAIL full_data: extra word %h expected none", out_data); end
        else begin exp_w = exp_q.pop_front(); if (out_data !== exp_w) begin n_errors++; $display("FAIL full_data: got %h expected %h", out_data, exp_w); end end
        got++;
      end
      if (done === 1'b1) done_k = k;
    end
    n_checks++; if (first_k != 2) begin n_errors++; $display("FAIL full_latency: first valid at k=%0d expected 2", first_k); end
    n_checks++; if (done_k != 34) begin n_errors++; $display("FAIL full_done_time: done at k=%0d expected 34", done_k); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL full_busy_at_done: got %b expected 0", busy); end
    n_checks++; if (got != 32 || exp_q.size() != 0) begin n_errors++; $display("FAIL full_count: got %0d words expected 32", got); end
    step();
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL full_done_pulse: got %b expected 0", done); end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    int done_k = -1;
    logic [31:0] exp_w;
    logic [4:0]  exp_adr;
    out_ready = 1'b1;
    expect_words(5'd30, 4);
    issue_cmd(5'd30, 6'd4);
    n_checks++; if (sram_adr !== 5'd30) begin n_errors++; $display("FAIL wrap_adr0: got %0d expected 30", sram_adr); end
    for (int k = 1; k <= 20 && done_k < 0; k++) begin
      step();
      if (k <= 3) begin
        exp_adr = 5'(30 + k);
        n_checks++; if (sram_adr !== exp_adr) begin n_errors++; $display("FAIL wrap_adr: got %0d expected %0d", sram_adr, exp_adr); end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_errors++; $display("FAIL wrap_data: extra word %h expected none", out_data); end
        else begin exp_w = exp_q.pop_front(); if (out_data !== exp_w) begin n_errors++; $display("FAIL wrap_data: got %h expected %h", out_data, exp_w); end end
      end
      if (done === 1'b1) done_k = k;
    end
    n_checks++; if (done_k != 6 || exp_q.size() != 0) begin n_errors++; $display("FAIL wrap_done: done at k=%0d, %0d words left, expected k=6 and 0", done_k, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int done_k = -1;
    int got    = 0;
    logic [31:0] exp_w;
    out_ready = 1'b1;
    expect_words(5'd5, 8);
    issue_cmd(5'd5, 6'd8);
    for (int k = 1; k <= 40 && done_k < 0; k++) begin
      step();
      // Consumer stalls for the six edges following the first valid cycle.
      out_ready = !(k >= 2 && k < 8);
      if (k >= 2 && k < 8) begin
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hA500_0005) begin n_errors++; $display("FAIL bp_hold: valid=%b data=%h expected 1 a5000005", out_valid, out_data); end
      end
      if (k == 7) begin
        n_checks++; if (sram_adr !== 5'd8 || dbg_state !== ISSUE) begin n_errors++; $display("FAIL bp_stall: adr=%0d state=%0d expected adr=8 ISSUE", sram_adr, dbg_state); end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_errors++; $display("FAIL bp_data: extra word %h expected none", out_data); end
        else begin exp_w = exp_q.pop_front(); if (out_data !== exp_w) begin n_errors++; $display("FAIL bp_data: got %h expected %h", out_data, exp_w); end end
        got++;
      end
      if (done === 1'b1) done_k = k;
    end
    out_ready = 1'b1;
    n_checks++; if (got != 8 || exp_q.size() != 0) begin n_errors++; $display("FAIL bp_count: got %0d words expected 8", got); end
    n_checks++; if (done_k != 16) begin n_errors++; $display("FAIL bp_done_time: done at k=%0d expected 16", done_k); end
    exp_q.delete();
  endtask

  task automatic test_len_zero();
    logic seen = 1'b0;
    issue_cmd(5'd3, 6'd0);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL zero_done: done=%b busy=%b expected done=1 busy=0", done, busy); end
    step();
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL zero_pulse: done=%b expected 0", done); end
    for (int k = 2; k <= 6; k++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      step();
    end
    n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL zero_quiet: activity=%b expected 0", seen); end
  endtask

  task automatic test_start_while_busy();
    int done_k = -1;
    int got    = 0;
    logic quiet = 1'b1;
    logic [31:0] exp_w;
    expect_words(5'd10, 3);
    issue_cmd(5'd10, 6'd3);
    issue_cmd(5'd20, 6'd5);   // lands at k=1, must be ignored
    n_checks++; if (sram_adr !== 5'd11) begin n_errors++; $display("FAIL busy_start_adr: got %0d expected 11", sram_adr); end
    for (int k = 2; k <= 20 && done_k < 0; k++) begin
      step();
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_errors++; $display("FAIL busy_start_data: extra word %h expected none", out_data); end
        else begin exp_w = exp_q.pop_front(); if (out_data !== exp_w) begin n_errors++; $display("FAIL busy_start_data: got %h expected %h", out_data, exp_w); end end
        got++;
      end
      if (done === 1'b1) done_k = k;
    end
    repeat (4) begin step(); if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0; end
    n_checks++; if (done_k != 5 || got != 3 || quiet !== 1'b1) begin n_errors++; $display("FAIL busy_start_result: done k=%0d words=%0d quiet=%b expected 5 3 1", done_k, got, quiet); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int done_k = -1;
    logic [31:0] exp_w;
    expect_words(5'd0, 2);
    expect_words(5'd7, 1);
    issue_cmd(5'd0, 6'd2);
    for (int k = 1; k <= 10 && done_k < 0; k++) begin
      step();
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        exp_w = exp_q.pop_front();
        n_checks++; if (out_data !== exp_w) begin n_errors++; $display("FAIL b2b_data_a: got %h expected %h", out_data, exp_w); end
      end
      if (done === 1'b1) done_k = k;
    end
    n_checks++; if (done_k != 4) begin n_errors++; $display("FAIL b2b_done_a: done at k=%0d expected 4", done_k); end
    issue_cmd(5'd7, 6'd1);   // accepted on the edge right after done
    n_checks++; if (busy !== 1'b1 || sram_adr !== 5'd7) begin n_errors++; $display("FAIL b2b_accept: busy=%b adr=%0d expected 1 7", busy, sram_adr); end
    done_k = -1;
    for (int k = 1; k <= 10 && done_k < 0; k++) begin
      step();
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_errors++; $display("FAIL b2b_data_b: extra word %h expected none", out_data); end
        else begin exp_w = exp_q.pop_front(); if (out_data !== exp_w) begin n_errors++; $display("FAIL b2b_data_b: got %h expected %h", out_data, exp_w); end end
      end
      if (done === 1'b1) done_k = k;
    end
    n_checks++; if (done_k != 3 || exp_q.size() != 0) begin n_errors++; $display("FAIL b2b_done_b: done at k=%0d left=%0d expected 3 0", done_k, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_burst();
    int done_k = -1;
    int got    = 0;
    logic quiet = 1'b1;
    logic [31:0] exp_w;
    expect_words(5'd0, 2);
    issue_cmd(5'd0, 6'd10);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k < 4 && out_valid === 1'b1 && out_ready === 1'b1) begin
        exp_w = exp_q.pop_front();
        n_checks++; if (out_data !== exp_w) begin n_errors++; $display("FAIL rstmid_pre: got %h expected %h", out_data, exp_w); end
      end
    end
    // k=4: third word is on the stream; reset on the next edge.
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL rstmid_ctrl: busy=%b done=%b expected 0 0", busy, done); end
    n_checks++; if (sram_adr !== 5'd0) begin n_errors++; $display("FAIL rstmid_adr: got %0d expected 0", sram_adr); end
    n_checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin n_errors++; $display("FAIL rstmid_stream: valid=%b data=%h expected 0 0", out_valid, out_data); end
    n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL rstmid_state: got %0d expected IDLE", dbg_state); end
    repeat (6) begin step(); if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) quiet = 1'b0; end
    n_checks++; if (quiet !== 1'b1) begin n_errors++; $display("FAIL rstmid_quiet: got %b expected 1", quiet); end
    exp_q.delete();
    expect_words(5'd2, 2);
    issue_cmd(5'd2, 6'd2);
    for (int k = 1; k <= 10 && done_k < 0; k++) begin
      step();
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_errors++; $display("FAIL rstmid_data: extra word %h expected none", out_data); end
        else begin exp_w = exp_q.pop_front(); if (out_data !== exp_w) begin n_errors++; $display("FAIL rstmid_data: got %h expected %h", out_data, exp_w); end end
        got++;
      end
      if (done === 1'b1) done_k = k;
    end
    n_checks++; if (done_k != 4 || got != 2) begin n_errors++; $display("FAIL rstmid_done: done at k=%0d words=%0d expected 4 2", done_k, got); end
    exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 + 32'(i);
    rst       = 1'b1;
    start     = 1'b0;
    base      = '0;
    len       = '0;
    out_ready = 1'b1;
    n_checks  = 0;
    n_errors  = 0;

    test_reset();
    test_full_burst();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_burst();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
